button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end stage feeding the countdown timer block's five button inputs (up, down, left, right, action).
- Synchronises raw pushbutton levels into clk, debounces each one independently, and emits exactly one single-cycle pulse per accepted press.
- The timer's step, digit and start/stop logic can therefore run synchronously on clean pulses instead of raw levels.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from the stable level before the stable level flips (10 ms at 100 MHz); legal range >= 2.
- REPEAT_DELAY, 50000000, cycles from the press pulse to the first auto-repeat pulse (only with AUTO_REPEAT_EN).
- REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses (only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  5  raw button levels, active-high, asynchronous to clk; bit0 up, bit1 down, bit2 left, bit3 right, bit4 action.
- btn_level  out  5  debounced stable levels, same bit order.
- btn_pulse  out  5  one-cycle press pulses, same bit order; drives the timer's up/down/left/right/action inputs.

Behaviour:
- Reset (rst_n low, asynchronous): both synchroniser stages, btn_level, btn_pulse, all debounce counters and all repeat counters clear to 0. Reset release does not produce pulses.
- Synchroniser: two flops per bit. s2 is the synchronised level.
- Debounce, per bit, counter of width $clog2(DEBOUNCE_CYCLES):
  - If s2 == btn_level: counter clears.
  - Else, if counter == DEBOUNCE_CYCLES-1: btn_level takes s2 and counter clears.
  - Else: counter increments.
  - Any single cycle of s2 == btn_level during a count restarts the count from 0 (glitch rejection).
- Latency: with btn_raw held high from the edge that first samples it, btn_level rises on the (DEBOUNCE_CYCLES+1)th subsequent rising edge. Release uses the same latency.
- Pulse: btn_pulse[i] is registered and high for exactly one cycle, in the same cycle btn_level[i] goes 0->1. Release (1->0) produces no pulse.
- Bits are fully independent. Simultaneous presses on several bits produce simultaneous pulses; there is no priority or suppression (the consumer resolves conflicts).
- A button held through reset release is debounced from scratch: one pulse appears DEBOUNCE_CYCLES+1 edges after release, if still held.
- Counters saturate nowhere. A bounce-free held button produces exactly one pulse, except as extended by the optional feature.
- Clean-release rule: while rst_n is high, no pulse may ever occur without a preceding 0->1 transition of btn_level.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: up (bit0) and down (bit1) auto-repeat.
  - A per-bit repeat counter runs while btn_level[i] is high and the opposite bit (down/up) is low.
  - First extra pulse occurs REPEAT_DELAY cycles after the press pulse; further pulses every REPEAT_RATE cycles.
  - Release of the bit, or the opposite bit becoming high, clears the counter immediately; no pulse occurs in that cycle.
  - Left, right and action never repeat.
- Not defined: no repeat counters are synthesised; every bit gives one pulse per press.

Test Plan:
- DEBOUNCE_CYCLES=4, assert rst_n low then high, btn_raw=0 -> btn_level=0, btn_pulse=0 for 20 cycles.
- DEBOUNCE_CYCLES=4, btn_raw[4] 0->1 held -> btn_pulse[4] high for exactly one cycle, on the 5th edge after first sample; btn_level[4]=1 thereafter. Release -> btn_level[4]=0 5 edges later, no pulse.
- DEBOUNCE_CYCLES=4, btn_raw[0] toggles high 3 cycles, low 1, high 3, low -> btn_level[0] and btn_pulse[0] remain 0 throughout.
- btn_raw[2] and btn_raw[3] rise on the same edge -> btn_pulse[2] and btn_pulse[3] pulse on the same cycle. Pull rst_n low mid-count -> all outputs 0 immediately, asynchronously.
- AUTO_REPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, hold btn_raw[0] 30 cycles -> pulses at the press cycle P, then P+10, P+13, P+16, ... until release. Also raise btn_raw[1] during the hold -> repeating stops, and one pulse appears on bit1.
- Without AUTO_REPEAT_EN, same hold on btn_raw[0] -> exactly one pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// Five-button front end: 2-flop sync, per-bit debounce, one registered pulse per press; level/pulse lag raw by DEBOUNCE_CYCLES+1 edges after first sample.
// No backpressure (free-running outputs). Define AUTO_REPEAT_EN to add hold-to-repeat pulses on up (bit0) and down (bit1).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gBadParams
        $error("button_conditioner: illegal parameter values");
    end

    logic [4:0]    syncS1;
    logic [4:0]    syncS2;
    logic [CW-1:0] dbCnt     [5];
    logic [CW-1:0] dbCntNext [5];
    logic [4:0]    levelNext;
    logic [4:0]    rise;
    logic [4:0]    rptPulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncS1 <= '0;
            syncS2 <= '0;
        end else begin
            syncS1 <= btn_raw;
            syncS2 <= syncS1;
        end
    end

    // Any cycle where the synced input agrees with the stable level restarts the count.
    always_comb begin
        levelNext = btn_level;
        for (int i = 0; i < 5; i++) begin
            dbCntNext[i] = '0;
            if (syncS2[i] != btn_level[i]) begin
                if (dbCnt[i] == DB_LAST) begin
                    levelNext[i] = syncS2[i];
                end else begin
                    dbCntNext[i] = dbCnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = levelNext & ~btn_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                dbCnt[i] <= '0;
            end
            btn_level <= '0;
            btn_pulse <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                dbCnt[i] <= dbCntNext[i];
            end
            btn_level <= levelNext;
            btn_pulse <= rise | rptPulse;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rptCnt     [2];
    logic [RW-1:0] rptCntNext [2];
    logic [1:0]    rptArmed;
    logic [1:0]    rptArmedNext;

    // Runs only while the level is high now and stays high, and the opposite
    // direction is not becoming/being held; so press, release and conflict edges never repeat.
    always_comb begin
        rptPulse     = '0;
        rptArmedNext = rptArmed;
        for (int i = 0; i < 2; i++) begin
            logic oppNext;
            logic run;
            oppNext       = (i == 0) ? levelNext[1] : levelNext[0];
            run           = btn_level[i] & levelNext[i] & ~oppNext;
            rptCntNext[i] = '0;
            if (!run) begin
                rptArmedNext[i] = 1'b0;
            end else if (rptCnt[i] == (rptArmed[i] ? RATE_LAST : DELAY_LAST)) begin
                rptPulse[i]     = 1'b1;
                rptArmedNext[i] = 1'b1;
            end else begin
                rptCntNext[i] = rptCnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptCnt[0] <= '0;
            rptCnt[1] <= '0;
            rptArmed  <= '0;
        end else begin
            rptCnt[0] <= rptCntNext[0];
            rptCnt[1] <= rptCntNext[1];
            rptArmed  <= rptArmedNext;
        end
    end
`else
    assign rptPulse = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Expected repeat behaviour follows whether AUTO_REPEAT_EN is defined for the build.
module tb_button_conditioner;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    int tests;
    int failed;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] expP;
        logic [4:0] expL;
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        btn_raw = '0;

        // Reset state and quiet idle
        tick();
        tick();
        chk("reset_level", btn_level, 5'b00000);
        chk("reset_pulse", btn_pulse, 5'b00000);
        rst_n = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk("idle_level", btn_level, 5'b00000);
            chk("idle_pulse", btn_pulse, 5'b00000);
        end

        // Action press: first sample on tick 1, level/pulse on tick 6
        btn_raw = 5'b10000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("press4_pulse", btn_pulse, (t == 6) ? 5'b10000 : 5'b00000);
            chk("press4_level", btn_level, (t >= 6) ? 5'b10000 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("rel4_pulse", btn_pulse, 5'b00000);
            chk("rel4_level", btn_level, (t >= 6) ? 5'b00000 : 5'b10000);
        end

        // Bouncy up: 3 high, 1 low, 3 high, then low -> rejected
        for (int t = 1; t <= 16; t++) begin
            btn_raw = (t <= 3 || (t >= 5 && t <= 7)) ? 5'b00001 : 5'b00000;
            tick();
            chk("glitch_level", btn_level, 5'b00000);
            chk("glitch_pulse", btn_pulse, 5'b00000);
        end

        // Left and right together
        btn_raw = 5'b01100;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("lr_pulse", btn_pulse, (t == 6) ? 5'b01100 : 5'b00000);
            chk("lr_level", btn_level, (t >= 6) ? 5'b01100 : 5'b00000);
        end

        // Asynchronous reset in the middle of an action count
        btn_raw = 5'b11100;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", btn_level, 5'b00000);
        chk("arst_pulse", btn_pulse, 5'b00000);
        tick();
        tick();
        chk("arst_hold_level", btn_level, 5'b00000);
        rst_n = 1'b1;
        // Held through reset release: debounced from scratch
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("post_rst_pulse", btn_pulse, (t == 6) ? 5'b11100 : 5'b00000);
            chk("post_rst_level", btn_level, (t >= 6) ? 5'b11100 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("post_rst_rel_pulse", btn_pulse, 5'b00000);
        end
        chk("post_rst_rel_level", btn_level, 5'b00000);

        // Held up for 30 cycles, then down joins: repeats (if enabled) stop, one down pulse
        btn_raw = 5'b00001;
        for (int t = 1; t <= 50; t++) begin
            tick();
            expP = 5'b00000;
            expL = 5'b00000;
            if (t == 6) expP[0] = 1'b1;
            if (AR && t >= 16 && t < 36 && ((t - 16) % 3) == 0) expP[0] = 1'b1;
            if (t == 36) expP[1] = 1'b1;
            if (t >= 6) expL[0] = 1'b1;
            if (t >= 36) expL[1] = 1'b1;
            chk("hold_pulse", btn_pulse, expP);
            chk("hold_level", btn_level, expL);
            if (t == 30) btn_raw = 5'b00011;
        end
        btn_raw = 5'b00000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("hold_rel_pulse", btn_pulse, 5'b00000);
            chk("hold_rel_level", btn_level, (t >= 6) ? 5'b00000 : 5'b00011);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
